// File: rtl/led_pattern_gen_if.sv
// Control and observation bundle for led_pattern_gen: upstream pulses and levels in,
// LED pattern, mode, wrap flag and debug state (step, tick counter) out.
interface led_pattern_gen_if #(
   parameter int LED_COUNT = 5,
   parameter int TICK_DIV  = 4
);
   localparam int SW = $clog2(2 * LED_COUNT);
   localparam int TW = $clog2(TICK_DIV);

   // No valid/ready handshake: next_led_re and change_mode_re are single-cycle
   // pulses sampled at every rising edge; auto_en and dir_down are levels.
   logic                 next_led_re;
   logic                 change_mode_re;
   logic                 auto_en;
   logic                 dir_down;
   logic [LED_COUNT-1:0] led;
   logic [1:0]           mode;
   logic                 wrap;
   logic [SW-1:0]        dbg_step;
   logic [TW-1:0]        dbg_tick;

   modport master (
      output next_led_re, change_mode_re, auto_en, dir_down,
      input  led, mode, wrap, dbg_step, dbg_tick
   );

   modport slave (
      input  next_led_re, change_mode_re, auto_en, dir_down,
      output led, mode, wrap, dbg_step, dbg_tick
   );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: four modes (single, bar, bounce, blink) stepped by manual
// pulses or a timed auto-advance tick, in either direction, with a wrap pulse.
module led_pattern_gen #(
   parameter int LED_COUNT = 5,
   parameter int TICK_DIV  = 4
) (
   input logic              clk,
   input logic              sync_nreset,
   led_pattern_gen_if.slave bus
);
   localparam int SW = $clog2(2 * LED_COUNT);
   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      M_SINGLE = 2'd0,
      M_BAR    = 2'd1,
      M_BOUNCE = 2'd2,
      M_BLINK  = 2'd3
   } mode_t;

   mode_t                r_mode;
   logic [SW-1:0]        r_step;
   logic [TW-1:0]        r_tick;
   logic                 r_wrap;

   logic                 w_tick;
   logic                 w_adv;
   logic [SW-1:0]        w_last;
   logic [SW-1:0]        w_step_nxt;
   logic                 w_wrap_evt;
   logic [LED_COUNT-1:0] w_led;
   int                   w_bar_len;
   int                   w_bounce_pos;

   assign w_tick = bus.auto_en && (r_tick == TW'(TICK_DIV - 1));
   assign w_adv  = bus.next_led_re || w_tick;

   // Highest legal step (period minus one) for the current mode.
   always_comb begin
      w_last = '0;
      case (r_mode)
         M_SINGLE: w_last = SW'(LED_COUNT);
         M_BAR:    w_last = SW'(2 * LED_COUNT - 1);
         M_BOUNCE: w_last = SW'(2 * LED_COUNT - 3);
         M_BLINK:  w_last = SW'(1);
         default:  w_last = '0;
      endcase
   end

   always_comb begin
      w_step_nxt = '0;
      w_wrap_evt = 1'b0;
      if (bus.dir_down) begin
         if (r_step == '0) begin
            w_step_nxt = w_last;
            w_wrap_evt = 1'b1;
         end else begin
            w_step_nxt = r_step - SW'(1);
         end
      end else begin
         if (r_step == w_last) begin
            w_step_nxt = '0;
            w_wrap_evt = 1'b1;
         end else begin
            w_step_nxt = r_step + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!sync_nreset) begin
         r_mode <= M_SINGLE;
         r_step <= '0;
         r_tick <= '0;
         r_wrap <= 1'b0;
      end else if (bus.change_mode_re) begin
         r_mode <= mode_t'(r_mode + 2'd1);
         r_step <= '0;
         r_tick <= '0;
         r_wrap <= 1'b0;
      end else begin
         if (!bus.auto_en)
            r_tick <= '0;
         else if (w_tick)
            r_tick <= '0;
         else
            r_tick <= r_tick + TW'(1);
         if (w_adv) begin
            r_step <= w_step_nxt;
            r_wrap <= w_wrap_evt;
         end else begin
            r_wrap <= 1'b0;
         end
      end
   end

   // Bar grows to full length then shrinks; bounce walks out and back without
   // repeating the end LEDs.
   assign w_bar_len    = (int'(r_step) <= LED_COUNT) ? int'(r_step) : 2 * LED_COUNT - int'(r_step);
   assign w_bounce_pos = (int'(r_step) <  LED_COUNT) ? int'(r_step) : 2 * LED_COUNT - 2 - int'(r_step);

   always_comb begin
      w_led = '0;
      for (int i = 0; i < LED_COUNT; i++) begin
         case (r_mode)
            M_SINGLE: w_led[i] = (int'(r_step) == i + 1);
            M_BAR:    w_led[i] = (i < w_bar_len);
            M_BOUNCE: w_led[i] = (i == w_bounce_pos);
            M_BLINK:  w_led[i] = (r_step != '0);
            default:  w_led[i] = 1'b0;
         endcase
      end
   end

   assign bus.led      = w_led;
   assign bus.mode     = r_mode;
   assign bus.wrap     = r_wrap;
   assign bus.dbg_step = r_step;
   assign bus.dbg_tick = r_tick;
endmodule
